// File: rtl/red_pitaya_relock_block.sv
// ----------------------------------------------------------------------------
// red_pitaya_relock_block
//
// Relock supervisor sitting downstream of the output limiter. It declares
// lock loss when the limiter stays railed for too long, then drives a
// triangular sweep offset while holding the PID integrator in reset. Once the
// lock monitor rises above threshold and stays there for a settle period, the
// loop is handed back to the PID.
//
// Ports
//   clk_i          ADC-domain clock
//   rstn_i         asynchronous active-low reset
//   enable_i       supervision enable; low forces DISABLED
//   railed_i       limiter flags {max,min}; nonzero means railed
//   mon_i          signed lock-quality monitor
//   mon_thr_i      signed lock threshold (locked when mon_i >= mon_thr_i)
//   railed_thr_i   consecutive railed cycles that declare lock loss (0 acts as 1)
//   settle_cyc_i   locked cycles required before release (0 acts as 1)
//   sweep_min_i    signed sweep lower bound
//   sweep_max_i    signed sweep upper bound
//   sweep_step_i   unsigned sweep increment per cycle
//   sweep_o        signed sweep offset for the actuator path
//   pid_rst_o      holds the PID integrator in reset while high
//   state_o        0=DISABLED 1=LOCKED 2=SWEEP 3=SETTLE
//   relock_cnt_o   saturating count of SWEEP entries caused by lock loss
//
// state    | meaning
// ---------+------------------------------------------------------------
// DISABLED | supervision off, sweep and PID reset released
// LOCKED   | loop closed, counting consecutive railed cycles
// SWEEP    | lock lost, triangle sweep running, PID integrator held
// SETTLE   | monitor above threshold, sweep frozen, waiting to release
// ----------------------------------------------------------------------------
module red_pitaya_relock_block #(
    parameter int CNTW = 20,
    parameter int RCW  = 16
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   enable_i,
    input  logic [1:0]             railed_i,
    input  logic signed [13:0]     mon_i,
    input  logic signed [13:0]     mon_thr_i,
    input  logic [CNTW-1:0]        railed_thr_i,
    input  logic [CNTW-1:0]        settle_cyc_i,
    input  logic signed [13:0]     sweep_min_i,
    input  logic signed [13:0]     sweep_max_i,
    input  logic [13:0]            sweep_step_i,
    output logic signed [13:0]     sweep_o,
    output logic                   pid_rst_o,
    output logic [1:0]             state_o,
    output logic [RCW-1:0]         relock_cnt_o
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_SWEEP    = 2'd2,
        ST_SETTLE   = 2'd3
    } state_t;

    state_t              r_state,      w_state_n;
    logic signed [13:0]  r_sweep,      w_sweep_n;
    logic                r_dir_up,     w_dir_up_n;
    logic                r_pid_rst,    w_pid_rst_n;
    logic [RCW-1:0]      r_relock_cnt, w_relock_cnt_n;
    logic [CNTW-1:0]     r_rail_cnt,   w_rail_cnt_n;
    logic [CNTW-1:0]     r_set_cnt,    w_set_cnt_n;

    logic                w_railed;
    logic                w_locked;
    logic [CNTW-1:0]     w_rail_thr;
    logic [CNTW-1:0]     w_set_thr;
    logic [CNTW:0]       w_rail_inc;
    logic [CNTW:0]       w_set_inc;

    // Sweep arithmetic carries two guard bits so that a full-range step from
    // either rail cannot wrap before the clamp sees it.
    logic signed [15:0]  w_sw_ext;
    logic signed [15:0]  w_step_ext;
    logic signed [15:0]  w_min_ext;
    logic signed [15:0]  w_max_ext;
    logic signed [15:0]  w_ramp_ext;
    logic signed [13:0]  w_ramp;
    logic                w_ramp_dir;

    assign w_railed   = |railed_i;
    assign w_locked   = (mon_i >= mon_thr_i);
    assign w_rail_thr = (railed_thr_i == '0) ? CNTW'(1) : railed_thr_i;
    assign w_set_thr  = (settle_cyc_i == '0) ? CNTW'(1) : settle_cyc_i;
    assign w_rail_inc = {1'b0, r_rail_cnt} + (CNTW+1)'(1);
    assign w_set_inc  = {1'b0, r_set_cnt} + (CNTW+1)'(1);

    assign w_sw_ext   = {{2{r_sweep[13]}}, r_sweep};
    assign w_step_ext = {2'b00, sweep_step_i};
    assign w_min_ext  = {{2{sweep_min_i[13]}}, sweep_min_i};
    assign w_max_ext  = {{2{sweep_max_i[13]}}, sweep_max_i};

    // Triangle ramp: direction is forced (not toggled) at each bound, so a
    // zero step sitting on a bound stays put instead of oscillating.
    always_comb begin
        w_ramp_ext = r_dir_up ? (w_sw_ext + w_step_ext) : (w_sw_ext - w_step_ext);
        w_ramp_dir = r_dir_up;
        if (w_min_ext > w_max_ext) begin
            w_ramp = sweep_min_i;
        end else if (w_ramp_ext >= w_max_ext) begin
            w_ramp     = sweep_max_i;
            w_ramp_dir = 1'b0;
        end else if (w_ramp_ext <= w_min_ext) begin
            w_ramp     = sweep_min_i;
            w_ramp_dir = 1'b1;
        end else begin
            w_ramp = w_ramp_ext[13:0];
        end
    end

    always_comb begin
        w_state_n      = r_state;
        w_sweep_n      = r_sweep;
        w_dir_up_n     = r_dir_up;
        w_pid_rst_n    = r_pid_rst;
        w_relock_cnt_n = r_relock_cnt;
        w_rail_cnt_n   = r_rail_cnt;
        w_set_cnt_n    = r_set_cnt;

        if (!enable_i) begin
            // Disable dominates everything, including a same-cycle lock loss.
            w_state_n    = ST_DISABLED;
            w_sweep_n    = '0;
            w_dir_up_n   = 1'b1;
            w_pid_rst_n  = 1'b0;
            w_rail_cnt_n = '0;
            w_set_cnt_n  = '0;
        end else begin
            case (r_state)
                ST_DISABLED: begin
                    w_state_n    = ST_LOCKED;
                    w_pid_rst_n  = 1'b0;
                    w_rail_cnt_n = '0;
                    w_set_cnt_n  = '0;
                end
                ST_LOCKED: begin
                    w_pid_rst_n = 1'b0;
                    if (w_railed) begin
                        if (w_rail_inc >= {1'b0, w_rail_thr}) begin
                            w_state_n    = ST_SWEEP;
                            w_sweep_n    = sweep_min_i;
                            w_dir_up_n   = 1'b1;
                            w_pid_rst_n  = 1'b1;
                            w_rail_cnt_n = '0;
                            if (r_relock_cnt != '1) begin
                                w_relock_cnt_n = r_relock_cnt + RCW'(1);
                            end
                        end else begin
                            w_rail_cnt_n = w_rail_inc[CNTW-1:0];
                        end
                    end else begin
                        w_rail_cnt_n = '0;
                    end
                end
                ST_SWEEP: begin
                    w_pid_rst_n = 1'b1;
                    if (w_locked) begin
                        // Freeze the sweep where lock was found.
                        w_state_n   = ST_SETTLE;
                        w_pid_rst_n = 1'b0;
                        w_set_cnt_n = '0;
                    end else begin
                        w_sweep_n  = w_ramp;
                        w_dir_up_n = w_ramp_dir;
                    end
                end
                ST_SETTLE: begin
                    w_pid_rst_n = 1'b0;
                    if (!w_locked) begin
                        // Resume sweeping from the held value; not a new relock event.
                        w_state_n   = ST_SWEEP;
                        w_pid_rst_n = 1'b1;
                        w_set_cnt_n = '0;
                    end else if (w_set_inc >= {1'b0, w_set_thr}) begin
                        w_state_n    = ST_LOCKED;
                        w_rail_cnt_n = '0;
                        w_set_cnt_n  = '0;
                    end else begin
                        w_set_cnt_n = w_set_inc[CNTW-1:0];
                    end
                end
                default: begin
                    w_state_n = ST_DISABLED;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= ST_DISABLED;
            r_sweep      <= '0;
            r_dir_up     <= 1'b1;
            r_pid_rst    <= 1'b0;
            r_relock_cnt <= '0;
            r_rail_cnt   <= '0;
            r_set_cnt    <= '0;
        end else begin
            r_state      <= w_state_n;
            r_sweep      <= w_sweep_n;
            r_dir_up     <= w_dir_up_n;
            r_pid_rst    <= w_pid_rst_n;
            r_relock_cnt <= w_relock_cnt_n;
            r_rail_cnt   <= w_rail_cnt_n;
            r_set_cnt    <= w_set_cnt_n;
        end
    end

    assign sweep_o      = r_sweep;
    assign pid_rst_o    = r_pid_rst;
    assign state_o      = r_state;
    assign relock_cnt_o = r_relock_cnt;

endmodule

// File: tb/tb_red_pitaya_relock_block.sv
module tb_red_pitaya_relock_block;

    localparam int CNTW = 20;
    localparam int RCW  = 16;

    logic                   clk_i = 1'b0;
    logic                   rstn_i = 1'b0;
    logic                   enable_i = 1'b0;
    logic [1:0]             railed_i = 2'b00;
    logic signed [13:0]     mon_i = 14'sd0;
    logic signed [13:0]     mon_thr_i = 14'sd3000;
    logic [CNTW-1:0]        railed_thr_i = CNTW'(10);
    logic [CNTW-1:0]        settle_cyc_i = CNTW'(50);
    logic signed [13:0]     sweep_min_i = -14'sd1000;
    logic signed [13:0]     sweep_max_i = 14'sd1000;
    logic [13:0]            sweep_step_i = 14'd300;
    logic signed [13:0]     sweep_o;
    logic                   pid_rst_o;
    logic [1:0]             state_o;
    logic [RCW-1:0]         relock_cnt_o;

    red_pitaya_relock_block #(.CNTW(CNTW), .RCW(RCW)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .enable_i     (enable_i),
        .railed_i     (railed_i),
        .mon_i        (mon_i),
        .mon_thr_i    (mon_thr_i),
        .railed_thr_i (railed_thr_i),
        .settle_cyc_i (settle_cyc_i),
        .sweep_min_i  (sweep_min_i),
        .sweep_max_i  (sweep_max_i),
        .sweep_step_i (sweep_step_i),
        .sweep_o      (sweep_o),
        .pid_rst_o    (pid_rst_o),
        .state_o      (state_o),
        .relock_cnt_o (relock_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]         st;
        logic signed [13:0] sw;
        logic               pid;
        logic [RCW-1:0]     cnt;
    } exp_t;

    typedef struct {
        logic               en;
        logic [1:0]         rl;
        logic signed [13:0] mon;
        logic               chk;
        exp_t               e;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(logic en, logic [1:0] rl, int mon, logic chk,
                                int st, int sw, logic pid, int cnt);
        vec_t v;
        v.en    = en;
        v.rl    = rl;
        v.mon   = 14'(mon);
        v.chk   = chk;
        v.e.st  = 2'(st);
        v.e.sw  = 14'(sw);
        v.e.pid = pid;
        v.e.cnt = RCW'(cnt);
        return v;
    endfunction

    task automatic check_out(string name, exp_t e);
        n_checks++;
        if (state_o !== e.st) begin
            n_fail++;
            $display("FAIL %s state_o got %0d expected %0d", name, state_o, e.st);
        end
        n_checks++;
        if (sweep_o !== e.sw) begin
            n_fail++;
            $display("FAIL %s sweep_o got %0d expected %0d", name, sweep_o, e.sw);
        end
        n_checks++;
        if (pid_rst_o !== e.pid) begin
            n_fail++;
            $display("FAIL %s pid_rst_o got %0b expected %0b", name, pid_rst_o, e.pid);
        end
        n_checks++;
        if (relock_cnt_o !== e.cnt) begin
            n_fail++;
            $display("FAIL %s relock_cnt_o got %0d expected %0d", name, relock_cnt_o, e.cnt);
        end
    endtask

    // Drive one vector, let one edge pass, then score the popped expectation.
    task automatic apply(vec_t v, string name);
        exp_t e;
        enable_i = v.en;
        railed_i = v.rl;
        mon_i    = v.mon;
        if (v.chk) sb_q.push_back(v.e);
        @(posedge clk_i);
        #1;
        if (v.chk) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s scoreboard empty", name);
            end else begin
                e = sb_q.pop_front();
                check_out(name, e);
            end
        end
    endtask

    task automatic run_tbl(string name);
        foreach (tbl[i]) apply(tbl[i], $sformatf("%s[%0d]", name, i));
        tbl.delete();
    endtask

    int ramp_exp [18] = '{-700, -400, -100, 200, 500, 800, 1000, 700, 400,
                          100, -200, -500, -800, -1000, -700, -400, -100, 200};

    initial begin
        exp_t e0;
        e0.st = 2'd0; e0.sw = 14'sd0; e0.pid = 1'b0; e0.cnt = '0;

        #2;
        check_out("reset", e0);
        #10;
        rstn_i = 1'b1;

        // Enable, idle with no rails.
        tbl.push_back(mk(1, 2'b00, 0, 1, 1, 0, 0, 0));
        for (int i = 0; i < 98; i++) tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2'b00, 0, 1, 1, 0, 0, 0));
        run_tbl("enable");

        // Railed persistence: 9 railed, one clear, then 10 railed.
        for (int i = 0; i < 9; i++) tbl.push_back(mk(1, 2'b01, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 2'b00, 0, 1, 1, 0, 0, 0));
        for (int i = 0; i < 9; i++) tbl.push_back(mk(1, 2'b01, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 2'b01, 0, 1, 2, -1000, 1, 1));
        run_tbl("rail");

        // Triangle ramp; rail flags toggled to show they are ignored.
        for (int i = 0; i < 18; i++)
            tbl.push_back(mk(1, (i % 2) ? 2'b10 : 2'b00, 0, 1, 2, ramp_exp[i], 1, 1));
        run_tbl("ramp");

        // Lock found at 200, settle interrupted on the 20th cycle.
        for (int i = 0; i < 20; i++) tbl.push_back(mk(1, 2'b00, 5000, 1, 3, 200, 0, 1));
        tbl.push_back(mk(1, 2'b00, 0, 1, 2, 200, 1, 1));
        tbl.push_back(mk(1, 2'b00, 0, 1, 2, 500, 1, 1));
        run_tbl("settle_drop");

        // Lock at 500, full 50-cycle settle then release.
        tbl.push_back(mk(1, 2'b11, 5000, 1, 3, 500, 0, 1));
        for (int i = 0; i < 49; i++) tbl.push_back(mk(1, 2'b11, 5000, 1, 3, 500, 0, 1));
        tbl.push_back(mk(1, 2'b00, 5000, 1, 1, 500, 0, 1));
        run_tbl("settle_full");

        // railed_thr 0 behaves as 1.
        railed_thr_i = '0;
        tbl.push_back(mk(1, 2'b10, 0, 1, 2, -1000, 1, 2));
        run_tbl("thr0");

        // Zero step holds.
        sweep_step_i = 14'd0;
        tbl.push_back(mk(1, 2'b00, 0, 1, 2, -1000, 1, 2));
        tbl.push_back(mk(1, 2'b00, 0, 1, 2, -1000, 1, 2));
        run_tbl("step0");

        // Inverted bounds pin the sweep at sweep_min_i.
        sweep_min_i  = 14'sd500;
        sweep_max_i  = -14'sd500;
        sweep_step_i = 14'd300;
        tbl.push_back(mk(1, 2'b00, 0, 1, 2, 500, 1, 2));
        tbl.push_back(mk(1, 2'b00, 0, 1, 2, 500, 1, 2));
        run_tbl("inv_bounds");

        sweep_min_i = -14'sd1000;
        sweep_max_i = 14'sd1000;
        tbl.push_back(mk(1, 2'b00, 0, 1, 2, 800, 1, 2));
        // Disable mid-sweep, re-enable, then disable racing a lock loss.
        tbl.push_back(mk(0, 2'b01, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk(1, 2'b00, 0, 1, 1, 0, 0, 2));
        tbl.push_back(mk(0, 2'b01, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk(1, 2'b00, 0, 1, 1, 0, 0, 2));
        tbl.push_back(mk(1, 2'b01, 0, 1, 2, -1000, 1, 3));
        tbl.push_back(mk(1, 2'b00, 0, 1, 2, -700, 1, 3));
        run_tbl("disable");

        // Asynchronous reset mid-sweep, checked before the next clock edge.
        #2;
        rstn_i = 1'b0;
        #1;
        check_out("async_rst", e0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
